// File: rtl/ldpc_dec_load_sched_pkg.sv
// Shared constants, mode codes and FSM encodings for the LDPC load scheduler.
// Imported by the scheduler top and its beat generator.
package ldpc_dec_load_sched_pkg;

    localparam logic [1:0] MODE_R23 = 2'd1;
    localparam logic [1:0] MODE_R78 = 2'd2;

    localparam int SUB_BEATS_DEF   = 16;
    localparam int TAIL_BEATS_DEF  = 128;
    localparam int APP_AW_DEF      = 5;
    localparam int TIMEOUT_CYC_DEF = 4096;

    localparam int CFG_P_DEF     = 32;
    localparam int APP_DEPTH_DEF = 16;
    localparam int CFG_JLS_DEF   = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CFG    = 3'd1,
        ST_ARM    = 3'd2,
        ST_LOAD   = 3'd3,
        ST_DECODE = 3'd4
    } sched_st_e;

    function automatic logic mode_legal(input logic [1:0] m);
        return (m == MODE_R23) || (m == MODE_R78);
    endfunction

endpackage

// File: rtl/ldpc_dec_load_sched_beat_gen.sv
// Sub-block / beat counter for one frame load.
// Walks sub_x and beat_idx while go is high and flags first and last beats.
module ldpc_dec_load_sched_beat_gen
    import ldpc_dec_load_sched_pkg::*;
#(
    parameter int SUB_BEATS  = SUB_BEATS_DEF,
    parameter int TAIL_BEATS = TAIL_BEATS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go_i,
    input  logic [1:0] mode_i,
    output logic [1:0] sub_x_o,
    output logic [7:0] beat_idx_o,
    output logic       start_o,
    output logic       last_o
);

    logic [1:0] sub_x_q, sub_x_d;
    logic [7:0] beat_q, beat_d;
    logic [1:0] last_sub;
    logic [7:0] blk_end;
    logic       blk_done;

    // Block length depends on whether we are in the mode-1 tail sub-block.
    always_comb begin
        last_sub = (mode_i == MODE_R23) ? 2'd3 : 2'd2;
        blk_end  = (sub_x_q == 2'd3) ? 8'(TAIL_BEATS - 1)
                                     : 8'(SUB_BEATS - 1);
        blk_done = (beat_q == blk_end);
        start_o  = go_i && (sub_x_q == 2'd0) && (beat_q == 8'd0);
        last_o   = go_i && blk_done && (sub_x_q == last_sub);
        sub_x_d  = sub_x_q;
        beat_d   = beat_q;
        if (go_i) begin
            if (last_o) begin
                sub_x_d = 2'd0;
                beat_d  = 8'd0;
            end else if (blk_done) begin
                sub_x_d = sub_x_q + 2'd1;
                beat_d  = 8'd0;
            end else begin
                beat_d  = beat_q + 8'd1;
            end
        end
    end

    // Counter registers; return to zero after the final beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            sub_x_q <= 2'd0;
            beat_q  <= 8'd0;
        end else begin
            sub_x_q <= sub_x_d;
            beat_q  <= beat_d;
        end
    end

    assign sub_x_o    = sub_x_q;
    assign beat_idx_o = beat_q;

endmodule

// File: rtl/ldpc_dec_load_sched.sv
// Frame scheduler between the LLR frame stager and the LDPC decoder core.
// Optional decode watchdog enabled by defining LDPC_SCHED_TIMEOUT_EN.
module ldpc_dec_load_sched
    import ldpc_dec_load_sched_pkg::*;
#(
    parameter int SUB_BEATS  = SUB_BEATS_DEF,
    parameter int TAIL_BEATS = TAIL_BEATS_DEF,
    parameter int APP_AW     = APP_AW_DEF
`ifdef LDPC_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_rdy,
    input  logic [1:0]        frame_mode,
    output logic              frame_release,
    input  logic              core_ready,
    input  logic              core_done,
    output logic              buf_valid,
    output logic              buf_start,
    output logic              buf_last,
    output logic [1:0]        sub_x,
    output logic [7:0]        beat_idx,
    output logic [2:0]        cfg_iLs,
    output logic [2:0]        cfg_jLs,
    output logic [5:0]        cfg_P,
    output logic [APP_AW-1:0] cfg_addr_max,
    output logic [APP_AW-1:0] cfg_addr_rd_max,
    output logic              busy,
    output logic              err_mode
`ifdef LDPC_SCHED_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    sched_st_e   st_q, st_d;
    logic [1:0]  mode_q, mode_d;
    logic        rel_q, rel_d;
    logic        done_q;
    logic        done_rise;
    logic        err_drop;
    logic        bg_go;
    logic        bg_last;

    logic [2:0]        cfg_iLs_q;
    logic [2:0]        cfg_jLs_q;
    logic [5:0]        cfg_P_q;
    logic [APP_AW-1:0] cfg_am_q;
    logic [APP_AW-1:0] cfg_arm_q;

`ifdef LDPC_SCHED_TIMEOUT_EN
    logic [15:0] tmo_q;
    logic        tmo_hit;
    assign tmo_hit = (tmo_q == 16'(TIMEOUT_CYC - 1));
`endif

    assign done_rise = core_done && !done_q;
    assign bg_go     = (st_q == ST_LOAD);

    // Next-state logic; release pulses come from drop or decode entry.
    always_comb begin
        st_d     = st_q;
        mode_d   = mode_q;
        rel_d    = 1'b0;
        err_drop = 1'b0;
`ifdef LDPC_SCHED_TIMEOUT_EN
        timeout_err = 1'b0;
`endif
        unique case (st_q)
            ST_IDLE: begin
                if (frame_rdy) begin
                    if (mode_legal(frame_mode)) begin
                        st_d   = ST_CFG;
                        mode_d = frame_mode;
                    end else begin
                        err_drop = 1'b1;
                    end
                end
            end
            ST_CFG: begin
                st_d = ST_ARM;
            end
            ST_ARM: begin
                if (core_ready) begin
                    st_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (bg_last) begin
                    st_d  = ST_DECODE;
                    rel_d = 1'b1;
                end
            end
            ST_DECODE: begin
                if (done_rise) begin
                    st_d = ST_IDLE;
`ifdef LDPC_SCHED_TIMEOUT_EN
                end else if (tmo_hit) begin
                    st_d        = ST_IDLE;
                    timeout_err = 1'b1;
`endif
                end
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase
    end

    // State, latched mode, release pulse and core_done edge history.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= ST_IDLE;
            mode_q <= 2'd0;
            rel_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            mode_q <= mode_d;
            rel_q  <= rel_d;
            done_q <= core_done;
        end
    end

    // Core configuration is captured once per frame in CFG.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_iLs_q <= 3'd0;
            cfg_jLs_q <= 3'd0;
            cfg_P_q   <= 6'(CFG_P_DEF);
            cfg_am_q  <= APP_AW'(APP_DEPTH_DEF);
            cfg_arm_q <= APP_AW'(APP_DEPTH_DEF - 1);
        end else if (st_q == ST_CFG) begin
            cfg_iLs_q <= {1'b0, mode_q};
            cfg_jLs_q <= 3'(CFG_JLS_DEF);
            cfg_P_q   <= 6'(CFG_P_DEF);
            cfg_am_q  <= APP_AW'(APP_DEPTH_DEF);
            cfg_arm_q <= APP_AW'(APP_DEPTH_DEF - 1);
        end
    end

`ifdef LDPC_SCHED_TIMEOUT_EN
    // Watchdog counts cycles spent waiting in DECODE.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= 16'd0;
        end else if (st_q == ST_DECODE) begin
            tmo_q <= tmo_q + 16'd1;
        end else begin
            tmo_q <= 16'd0;
        end
    end
`endif

    ldpc_dec_load_sched_beat_gen #(
        .SUB_BEATS  (SUB_BEATS),
        .TAIL_BEATS (TAIL_BEATS)
    ) u_beat_gen (
        .clk        (clk),
        .rst        (rst),
        .go_i       (bg_go),
        .mode_i     (cfg_iLs_q[1:0]),
        .sub_x_o    (sub_x),
        .beat_idx_o (beat_idx),
        .start_o    (buf_start),
        .last_o     (bg_last)
    );

    assign buf_last        = bg_last;
    assign buf_valid       = bg_go;
    assign frame_release   = rel_q || err_drop;
    assign err_mode        = err_drop;
    assign busy            = (st_q != ST_IDLE);
    assign cfg_iLs         = cfg_iLs_q;
    assign cfg_jLs         = cfg_jLs_q;
    assign cfg_P           = cfg_P_q;
    assign cfg_addr_max    = cfg_am_q;
    assign cfg_addr_rd_max = cfg_arm_q;

endmodule

// File: tb/tb_ldpc_dec_load_sched.sv
// Scoreboard bench for ldpc_dec_load_sched.
// Random frame sequence planned from the load rules, checked by a monitor.
module tb_ldpc_dec_load_sched;

    localparam int NC = 8192;
    localparam int NF = 14;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_rdy = 1'b0;
    logic [1:0] frame_mode = 2'd0;
    logic       core_ready = 1'b0;
    logic       core_done = 1'b0;
    logic       frame_release;
    logic       buf_valid, buf_start, buf_last;
    logic [1:0] sub_x;
    logic [7:0] beat_idx;
    logic [2:0] cfg_iLs, cfg_jLs;
    logic [5:0] cfg_P;
    logic [4:0] cfg_addr_max, cfg_addr_rd_max;
    logic       busy, err_mode;
`ifdef LDPC_SCHED_TIMEOUT_EN
    logic       timeout_err;
`endif

    ldpc_dec_load_sched dut (
`ifdef LDPC_SCHED_TIMEOUT_EN
        .timeout_err     (timeout_err),
`endif
        .clk             (clk),
        .rst             (rst),
        .frame_rdy       (frame_rdy),
        .frame_mode      (frame_mode),
        .frame_release   (frame_release),
        .core_ready      (core_ready),
        .core_done       (core_done),
        .buf_valid       (buf_valid),
        .buf_start       (buf_start),
        .buf_last        (buf_last),
        .sub_x           (sub_x),
        .beat_idx        (beat_idx),
        .cfg_iLs         (cfg_iLs),
        .cfg_jLs         (cfg_jLs),
        .cfg_P           (cfg_P),
        .cfg_addr_max    (cfg_addr_max),
        .cfg_addr_rd_max (cfg_addr_rd_max),
        .busy            (busy),
        .err_mode        (err_mode)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit         a_rdy[NC];
    logic [1:0] a_mode[NC];
    bit         a_cr[NC];
    bit         a_cd[NC];
    bit         a_rst[NC];
    bit         a_chk[NC];
    bit         a_busy[NC];

    int         pl_t[NF];
    int         pl_s[NF];
    int         pl_n[NF];
    int         pl_rel[NF];
    logic [1:0] pl_mode[NF];
    bit         pl_err[NF];
    bit         pl_full[NF];

    typedef struct {
        int         c;
        logic [1:0] sx;
        logic [7:0] bi;
        logic       st;
        logic       ls;
        logic [2:0] ils;
    } beat_t;

    typedef struct {
        int   c;
        logic err;
    } rel_t;

    beat_t bq[$];
    rel_t  rq[$];
    beat_t me;
    rel_t  mr;

    int n_tests = 0;
    int n_fail  = 0;
    int kn      = 0;
    int endc    = 0;
    bit run     = 1'b0;
    bit fin_req = 1'b0;
    bit fin_done = 1'b0;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Monitor: pushes expectations as frames are offered, pops on outputs.
    always @(negedge clk) begin
        if (run && !fin_req && cyc < NC) begin
            if (kn < NF && pl_t[kn] == cyc) begin
                for (int b = 0; b < pl_n[kn]; b++) begin
                    me.c = pl_s[kn] + b;
                    if (b < 48) begin
                        me.sx = 2'(b / 16);
                        me.bi = 8'(b % 16);
                    end else begin
                        me.sx = 2'd3;
                        me.bi = 8'(b - 48);
                    end
                    me.st  = (b == 0);
                    me.ls  = pl_full[kn] && (b == pl_n[kn] - 1);
                    me.ils = {1'b0, pl_mode[kn]};
                    bq.push_back(me);
                end
                if (pl_rel[kn] >= 0) begin
                    mr.c   = pl_rel[kn];
                    mr.err = pl_err[kn];
                    rq.push_back(mr);
                end
                kn = kn + 1;
            end

            n_tests++;
            if (busy !== a_busy[cyc]) begin
                n_fail++;
                $display("FAIL busy c=%0d: got %0b want %0b",
                         cyc, busy, a_busy[cyc]);
            end

            if (buf_valid) begin
                n_tests++;
                if (bq.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat c=%0d: got unexpected beat sx=%0d bi=%0d, want none",
                             cyc, sub_x, beat_idx);
                end else begin
                    me = bq.pop_front();
                    if (cyc != me.c || sub_x !== me.sx ||
                        beat_idx !== me.bi || buf_start !== me.st ||
                        buf_last !== me.ls || cfg_iLs !== me.ils ||
                        cfg_jLs !== 3'd1 || cfg_P !== 6'd32 ||
                        cfg_addr_max !== 5'd16 ||
                        cfg_addr_rd_max !== 5'd15) begin
                        n_fail++;
                        $display({"FAIL beat: got c=%0d sx=%0d bi=%0d st=%0b ls=%0b ",
                                  "ils=%0d jls=%0d P=%0d am=%0d arm=%0d, want c=%0d ",
                                  "sx=%0d bi=%0d st=%0b ls=%0b ils=%0d jls=1 P=32 am=16 arm=15"},
                                 cyc, sub_x, beat_idx, buf_start, buf_last,
                                 cfg_iLs, cfg_jLs, cfg_P, cfg_addr_max,
                                 cfg_addr_rd_max, me.c, me.sx, me.bi, me.st,
                                 me.ls, me.ils);
                    end
                end
            end else if (buf_start || buf_last) begin
                n_tests++;
                n_fail++;
                $display("FAIL strobe c=%0d: got start=%0b last=%0b without valid, want 0",
                         cyc, buf_start, buf_last);
            end

            if (frame_release || err_mode) begin
                n_tests++;
                if (rq.size() == 0) begin
                    n_fail++;
                    $display("FAIL release c=%0d: got rel=%0b err=%0b, want none",
                             cyc, frame_release, err_mode);
                end else begin
                    mr = rq.pop_front();
                    if (cyc != mr.c || err_mode !== mr.err ||
                        frame_release !== 1'b1) begin
                        n_fail++;
                        $display("FAIL release: got c=%0d rel=%0b err=%0b, want c=%0d rel=1 err=%0b",
                                 cyc, frame_release, err_mode, mr.c, mr.err);
                    end
                end
            end

            if (a_chk[cyc]) begin
                n_tests++;
                if (busy !== 1'b0 || buf_valid !== 1'b0 ||
                    sub_x !== 2'd0 || beat_idx !== 8'd0 ||
                    cfg_iLs !== 3'd0 || cfg_jLs !== 3'd0 ||
                    cfg_P !== 6'd32 || cfg_addr_max !== 5'd16 ||
                    cfg_addr_rd_max !== 5'd15 ||
                    frame_release !== 1'b0) begin
                    n_fail++;
                    $display({"FAIL reset_state c=%0d: got busy=%0b v=%0b sx=%0d bi=%0d ",
                              "ils=%0d jls=%0d P=%0d am=%0d arm=%0d rel=%0b, ",
                              "want 0 0 0 0 0 0 32 16 15 0"},
                             cyc, busy, buf_valid, sub_x, beat_idx, cfg_iLs,
                             cfg_jLs, cfg_P, cfg_addr_max, cfg_addr_rd_max,
                             frame_release);
                end
            end

`ifdef LDPC_SCHED_TIMEOUT_EN
            n_tests++;
            if (timeout_err !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout c=%0d: got %0b want 0", cyc, timeout_err);
            end
`endif
        end

        if (fin_req && !fin_done) begin
            n_tests++;
            if (bq.size() != 0 || rq.size() != 0 || kn != NF) begin
                n_fail++;
                $display("FAIL drain: got beats=%0d rels=%0d frames=%0d, want 0 0 %0d",
                         bq.size(), rq.size(), kn, NF);
            end
            fin_done = 1'b1;
        end
    end

    // Plan a random frame sequence, then replay it cycle by cycle.
    initial begin
        int idle_from, stage, t, r, s, n, rel, dd, h, rd, dn, c0, v;
        logic [1:0] m;

        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        c0 = cyc;
        a_chk[c0] = 1'b1;
        idle_from = c0 + 2;
        stage = c0 + 2;

        for (int f = 0; f < NF; f++) begin
            if (f == 0 || f == NF - 1) begin
                m = 2'd1;
            end else if (f == 1 || f == 4) begin
                m = 2'd2;
            end else if (f == 2) begin
                m = 2'd3;
            end else if (f == 3) begin
                m = 2'd0;
            end else begin
                v = $urandom_range(0, 19);
                m = (v == 0) ? 2'd0 : (v == 1) ? 2'd3 :
                    (v % 2 == 0) ? 2'd1 : 2'd2;
            end
            t = imax(stage, idle_from);
            for (int c = stage; c <= t; c++) begin
                a_rdy[c] = 1'b1;
                a_mode[c] = m;
            end
            pl_t[f] = t;
            pl_mode[f] = m;
            if (m == 2'd0 || m == 2'd3) begin
                pl_n[f] = 0;
                pl_s[f] = t;
                pl_rel[f] = t;
                pl_err[f] = 1'b1;
                pl_full[f] = 1'b0;
                idle_from = t + 1;
                stage = t + 1 + int'($urandom_range(0, 3));
            end else begin
                rd = (f == 0 || f == NF - 1) ? 0 :
                     (f == 4) ? 12 : int'($urandom_range(0, 12));
                r = t + rd;
                s = imax(t + 3, r + 1);
                n = (m == 2'd1) ? 176 : 48;
                pl_s[f] = s;
                pl_err[f] = 1'b0;
                if (f == NF - 1) begin
                    pl_n[f] = 21;
                    pl_full[f] = 1'b0;
                    pl_rel[f] = -1;
                    for (int c = t; c <= s + 20; c++) begin
                        a_rdy[c] = 1'b1;
                        a_mode[c] = m;
                    end
                    for (int c = r; c <= s + 20; c++) a_cr[c] = 1'b1;
                    for (int c = t + 1; c <= s + 20; c++) a_busy[c] = 1'b1;
                    a_rst[s + 20] = 1'b1;
                    a_chk[s + 21] = 1'b1;
                    idle_from = s + 21;
                end else begin
                    rel = s + n;
                    dd = $urandom_range(0, 15);
                    dn = rel + dd;
                    h = $urandom_range(1, 3);
                    for (int c = t; c <= rel; c++) begin
                        a_rdy[c] = 1'b1;
                        a_mode[c] = m;
                    end
                    for (int c = r; c <= dn; c++) a_cr[c] = 1'b1;
                    for (int c = t + 1; c <= dn; c++) a_busy[c] = 1'b1;
                    if ($urandom_range(0, 1) == 1) begin
                        for (int c = s + 10; c <= s + 12; c++) a_cr[c] = 1'b0;
                    end
                    if ($urandom_range(0, 1) == 1) a_cd[s + 5] = 1'b1;
                    for (int c = dn; c < dn + h; c++) a_cd[c] = 1'b1;
                    pl_n[f] = n;
                    pl_full[f] = 1'b1;
                    pl_rel[f] = rel;
                    idle_from = dn + 1;
                    stage = rel + 1 + int'($urandom_range(0, 20));
                end
            end
        end

        endc = idle_from + 8;
        if (endc >= NC) begin
            $display("FAIL plan: end cycle %0d exceeds limit %0d", endc, NC);
            $fatal(1);
        end
        run = 1'b1;

        for (int c = c0 + 1; c <= endc; c++) begin
            @(posedge clk);
            #1;
            rst        = a_rst[c];
            frame_rdy  = a_rdy[c];
            frame_mode = a_mode[c];
            core_ready = a_cr[c];
            core_done  = a_cd[c];
        end

        fin_req = 1'b1;
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
